vx_gpr_req_arb: RTL and testbench
=================================

VX_GPR_REQ_ARB -- requirements
Module: VX_gpr_req_arb

Interface
REQ-001 Parameter NUM_REQS, 4, number of GPR read requesters; SHALL be a power of two, at least 2.
REQ-002 Parameter REQ_BITS, $clog2(NUM_REQS), requester index width.
REQ-003 Port clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset; asserted when low.
REQ-005 Port req_valid  in  NUM_REQS  per-requester request valid.
REQ-006 Port req_wid  in  NUM_REQS*`NW_BITS  per-requester warp id.
REQ-007 Port req_rs1 / req_rs2 / req_rs3  in  NUM_REQS*`NR_BITS each  per-requester source register ids.
REQ-008 Port req_use_rs3  in  NUM_REQS  request needs a third operand.
REQ-009 Port req_ready  out  NUM_REQS  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 Port gpr_valid  out  1  GPR bank read beat valid.
REQ-011 Port gpr_ready  in  1  GPR bank accepts the beat.
REQ-012 Port gpr_wid  out  `NW_BITS, gpr_raddr_a / gpr_raddr_b  out  `NR_BITS each: beat warp id and the two read addresses.
REQ-013 Port gpr_tag  out  REQ_BITS, gpr_phase  out  1, gpr_last  out  1: granted requester, beat phase (0 = rs1/rs2, 1 = rs3), final beat of the request.

Function
REQ-014 FSM states IDLE (gpr_valid=0), BEAT0 (phase-0 beat held), BEAT1 (rs3 beat held); all gpr_* outputs SHALL be registered.
REQ-015 Slot free = IDLE, or BEAT0 with gpr_ready and latched use_rs3=0, or BEAT1 with gpr_ready; a grant SHALL occur only while the slot is free and some req_valid is high.
REQ-016 Round-robin: the search starts at pointer p and wraps modulo NUM_REQS; after granting index g, p SHALL become (g+1) mod NUM_REQS; p is unchanged when nothing is granted.
REQ-017 req_ready SHALL be combinational, at most one bit high, and high only for the granted index; req_ready SHALL be all-zero when no req_valid is high.
REQ-018 On grant, the next cycle SHALL show gpr_valid=1, phase=0, raddr_a=rs1, raddr_b=rs2, wid, tag=g, last=!use_rs3 (latency 1), and the FSM SHALL enter BEAT0.
REQ-019 BEAT0 with gpr_ready and latched use_rs3=1 SHALL load phase=1, raddr_a=rs3, raddr_b=0, last=1, with the same wid and tag, and SHALL enter BEAT1; no grant occurs in that cycle.
REQ-020 A beat accepted with no new grant SHALL return the FSM to IDLE with gpr_valid=0; a beat accepted with a grant SHALL load the new beat back-to-back with no bubble.
REQ-021 While gpr_valid=1 and gpr_ready=0, every gpr_* output SHALL hold stable and req_ready SHALL be all-zero.
REQ-022 A requester deasserting req_valid before its grant SHALL be skipped; no request is ever dropped after req_ready is high.

Reset
REQ-023 Reset low SHALL immediately force IDLE, gpr_valid=0, gpr_wid/raddr_a/raddr_b/tag/phase/last=0, and p=0, independent of clk.
REQ-024 Reset mid-request (BEAT0 or BEAT1) SHALL discard the in-flight request; after release, the first grant SHALL be searched from index 0.
REQ-025 req_ready SHALL be all-zero while reset is low.

Configuration
REQ-026 Macro GPR_REQ_RS3_EN: when defined, req_rs3, req_use_rs3 and BEAT1 SHALL exist as specified.
REQ-027 When GPR_REQ_RS3_EN is undefined, req_rs3, req_use_rs3 and BEAT1 SHALL be absent, every request SHALL be a single phase-0 beat with gpr_last=1, and the beat SHALL finish in BEAT0.

Verification
REQ-028 req_valid=4'b1111 held, gpr_ready=1, no rs3 -> grants 0,1,2,3,0 on consecutive cycles; gpr_tag follows one cycle later with gpr_valid high continuously.
REQ-029 Requester 2 with rs1=5, rs2=6, rs3=7, use_rs3=1, wid=3 -> beat (a=5, b=6, phase 0, last 0), then beat (a=7, b=0, phase 1, last 1), both with wid 3 and tag 2; no req_ready is high during the second beat's load cycle.
REQ-030 gpr_ready=0 for 3 cycles with a beat held -> gpr_* outputs are unchanged and req_ready=0 throughout; the beat is accepted on the 4th cycle.
REQ-031 Reset pulled low while in BEAT1 -> gpr_valid=0 without a clock edge; after release with req_valid=4'b1010, the first grant is index 1.
REQ-032 With GPR_REQ_RS3_EN undefined, 2 requests -> 2 single beats, each with last=1 and phase=0.

Source files
------------

// File: rtl/vx_gpr_req_arb.sv
// Round-robin arbiter that turns per-requester GPR read requests into registered bank-read beats.
// Optional third-operand support (rs3 beat / BEAT1) is enabled by defining GPR_REQ_RS3_EN.

`ifndef NW_BITS
`define NW_BITS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module vx_gpr_req_arb #(
  parameter int NUM_REQS = 4,
  parameter int REQ_BITS = $clog2(NUM_REQS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*`NW_BITS-1:0]  req_wid,
  input  logic [NUM_REQS*`NR_BITS-1:0]  req_rs1,
  input  logic [NUM_REQS*`NR_BITS-1:0]  req_rs2,
`ifdef GPR_REQ_RS3_EN
  input  logic [NUM_REQS*`NR_BITS-1:0]  req_rs3,
  input  logic [NUM_REQS-1:0]           req_use_rs3,
`endif
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          gpr_valid,
  input  logic                          gpr_ready,
  output logic [`NW_BITS-1:0]           gpr_wid,
  output logic [`NR_BITS-1:0]           gpr_raddr_a,
  output logic [`NR_BITS-1:0]           gpr_raddr_b,
  output logic [REQ_BITS-1:0]           gpr_tag,
  output logic                          gpr_phase,
  output logic                          gpr_last
);

  localparam int NW = `NW_BITS;
  localparam int NR = `NR_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1
`ifdef GPR_REQ_RS3_EN
    ,BEAT1 = 2'd2
`endif
  } state_t;

  state_t               state, state_n;
  logic [REQ_BITS-1:0]  rr_ptr, rr_ptr_n;
  logic                 valid_n, phase_n, last_n;
  logic [NW-1:0]        wid_n;
  logic [NR-1:0]        raddr_a_n, raddr_b_n;
  logic [REQ_BITS-1:0]  tag_n;

  logic [NW-1:0]        wid_arr [NUM_REQS];
  logic [NR-1:0]        rs1_arr [NUM_REQS];
  logic [NR-1:0]        rs2_arr [NUM_REQS];

`ifdef GPR_REQ_RS3_EN
  logic [NR-1:0]        rs3_arr [NUM_REQS];
  logic [NR-1:0]        rs3_q, rs3_n;
  logic                 use_rs3_q, use_rs3_n;
`endif

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
    assign wid_arr[g] = req_wid[g*NW +: NW];
    assign rs1_arr[g] = req_rs1[g*NR +: NR];
    assign rs2_arr[g] = req_rs2[g*NR +: NR];
`ifdef GPR_REQ_RS3_EN
    assign rs3_arr[g] = req_rs3[g*NR +: NR];
`endif
  end

  logic                 slot_free;
  logic                 found;
  logic [REQ_BITS-1:0]  grant_idx;
  logic                 grant;

  // The beat slot can take a new request when the held beat is retiring for good.
  always_comb begin
    slot_free = 1'b0;
    case (state)
      IDLE:  slot_free = 1'b1;
`ifdef GPR_REQ_RS3_EN
      BEAT0: slot_free = gpr_ready & ~use_rs3_q;
      BEAT1: slot_free = gpr_ready;
`else
      BEAT0: slot_free = gpr_ready;
`endif
      default: slot_free = 1'b0;
    endcase
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!found && req_valid[rr_ptr + REQ_BITS'(i)]) begin
        found     = 1'b1;
        grant_idx = rr_ptr + REQ_BITS'(i);
      end
    end
  end

  // Reset gates the grant so req_ready is quiet the instant reset drops.
  assign grant     = slot_free & found & reset;
  assign req_ready = grant ? (NUM_REQS'(1) << grant_idx) : '0;

  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    valid_n   = gpr_valid;
    wid_n     = gpr_wid;
    raddr_a_n = gpr_raddr_a;
    raddr_b_n = gpr_raddr_b;
    tag_n     = gpr_tag;
    phase_n   = gpr_phase;
    last_n    = gpr_last;
`ifdef GPR_REQ_RS3_EN
    rs3_n     = rs3_q;
    use_rs3_n = use_rs3_q;
`endif
    if (grant) begin
      state_n   = BEAT0;
      rr_ptr_n  = grant_idx + REQ_BITS'(1);
      valid_n   = 1'b1;
      wid_n     = wid_arr[grant_idx];
      raddr_a_n = rs1_arr[grant_idx];
      raddr_b_n = rs2_arr[grant_idx];
      tag_n     = grant_idx;
      phase_n   = 1'b0;
`ifdef GPR_REQ_RS3_EN
      last_n    = ~req_use_rs3[grant_idx];
      rs3_n     = rs3_arr[grant_idx];
      use_rs3_n = req_use_rs3[grant_idx];
`else
      last_n    = 1'b1;
`endif
    end else begin
      case (state)
        BEAT0: begin
          if (gpr_ready) begin
`ifdef GPR_REQ_RS3_EN
            if (use_rs3_q) begin
              state_n   = BEAT1;
              raddr_a_n = rs3_q;
              raddr_b_n = '0;
              phase_n   = 1'b1;
              last_n    = 1'b1;
            end else
`endif
            begin
              state_n = IDLE;
              valid_n = 1'b0;
            end
          end
        end
`ifdef GPR_REQ_RS3_EN
        BEAT1: begin
          if (gpr_ready) begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gpr_valid   <= 1'b0;
      gpr_wid     <= '0;
      gpr_raddr_a <= '0;
      gpr_raddr_b <= '0;
      gpr_tag     <= '0;
      gpr_phase   <= 1'b0;
      gpr_last    <= 1'b0;
`ifdef GPR_REQ_RS3_EN
      rs3_q       <= '0;
      use_rs3_q   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      gpr_valid   <= valid_n;
      gpr_wid     <= wid_n;
      gpr_raddr_a <= raddr_a_n;
      gpr_raddr_b <= raddr_b_n;
      gpr_tag     <= tag_n;
      gpr_phase   <= phase_n;
      gpr_last    <= last_n;
`ifdef GPR_REQ_RS3_EN
      rs3_q       <= rs3_n;
      use_rs3_q   <= use_rs3_n;
`endif
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
`endif

endmodule

// File: tb/tb_vx_gpr_req_arb.sv
// Directed bench for vx_gpr_req_arb: round-robin order, stalls, async reset and (if built) rs3 beats.

`ifndef NW_BITS
`define NW_BITS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module tb_vx_gpr_req_arb;

  localparam int NW = `NW_BITS;
  localparam int NR = `NR_BITS;

  logic          clk;
  logic          reset;
  logic [3:0]    req_valid;
  logic [4*NW-1:0] req_wid;
  logic [4*NR-1:0] req_rs1;
  logic [4*NR-1:0] req_rs2;
  logic [3:0]    req_ready;
  logic          gpr_valid;
  logic          gpr_ready;
  logic [NW-1:0] gpr_wid;
  logic [NR-1:0] gpr_raddr_a;
  logic [NR-1:0] gpr_raddr_b;
  logic [1:0]    gpr_tag;
  logic          gpr_phase;
  logic          gpr_last;

  logic [NW-1:0] wid_t [4];
  logic [NR-1:0] rs1_t [4];
  logic [NR-1:0] rs2_t [4];

`ifdef GPR_REQ_RS3_EN
  logic [4*NR-1:0] req_rs3;
  logic [3:0]      req_use_rs3;
  logic [NR-1:0]   rs3_t [4];
  logic            use_t [4];
`endif

  int vectors;
  int miscompares;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_wid[g*NW +: NW] = wid_t[g];
    assign req_rs1[g*NR +: NR] = rs1_t[g];
    assign req_rs2[g*NR +: NR] = rs2_t[g];
`ifdef GPR_REQ_RS3_EN
    assign req_rs3[g*NR +: NR] = rs3_t[g];
    assign req_use_rs3[g]      = use_t[g];
`endif
  end

  vx_gpr_req_arb #(.NUM_REQS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_wid     (req_wid),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
`ifdef GPR_REQ_RS3_EN
    .req_rs3     (req_rs3),
    .req_use_rs3 (req_use_rs3),
`endif
    .req_ready   (req_ready),
    .gpr_valid   (gpr_valid),
    .gpr_ready   (gpr_ready),
    .gpr_wid     (gpr_wid),
    .gpr_raddr_a (gpr_raddr_a),
    .gpr_raddr_b (gpr_raddr_b),
    .gpr_tag     (gpr_tag),
    .gpr_phase   (gpr_phase),
    .gpr_last    (gpr_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    req_valid = valid;
    gpr_ready = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_ready;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req_valid   = '0;
    gpr_ready   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wid_t[i] = NW'(i);
      rs1_t[i] = NR'(i + 1);
      rs2_t[i] = NR'(i + 10);
`ifdef GPR_REQ_RS3_EN
      rs3_t[i] = NR'(i + 20);
      use_t[i] = 1'b0;
`endif
    end

    // Asynchronous reset before any clock edge
    #2;
    reset     = 1'b0;
    req_valid = 4'hF;
    #1;
    checkOutput("reset_valid", gpr_valid, 0);
    checkOutput("reset_tag", gpr_tag, 0);
    checkOutput("reset_ready", req_ready, 4'b0000);
    tick();
    tick();
    checkOutput("reset_hold_valid", gpr_valid, 0);
    reset = 1'b1;

    // Round-robin with everyone requesting: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, 1'b1);
      exp_ready = 4'b0001 << (k % 4);
      checkOutput("rr_ready", req_ready, exp_ready);
      tick();
      checkOutput("rr_valid", gpr_valid, 1);
      checkOutput("rr_tag", gpr_tag, k % 4);
      checkOutput("rr_raddr_a", gpr_raddr_a, (k % 4) + 1);
      checkOutput("rr_raddr_b", gpr_raddr_b, (k % 4) + 10);
      checkOutput("rr_wid", gpr_wid, k % 4);
      checkOutput("rr_phase", gpr_phase, 0);
      checkOutput("rr_last", gpr_last, 1);
    end

    // Three stall cycles on the tag-0 beat, accepted on the fourth
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'hF, 1'b0);
      checkOutput("stall_ready", req_ready, 4'b0000);
      tick();
      checkOutput("stall_valid", gpr_valid, 1);
      checkOutput("stall_tag", gpr_tag, 0);
      checkOutput("stall_raddr_a", gpr_raddr_a, 1);
      checkOutput("stall_raddr_b", gpr_raddr_b, 10);
    end
    applyStimulus(4'hF, 1'b1);
    checkOutput("unstall_ready", req_ready, 4'b0010);
    tick();
    checkOutput("unstall_tag", gpr_tag, 1);
    checkOutput("unstall_raddr_a", gpr_raddr_a, 2);

    // Sparse requests: pointer at 2 skips to 3, then wraps to 0
    applyStimulus(4'b1001, 1'b1);
    checkOutput("gap_ready_3", req_ready, 4'b1000);
    tick();
    checkOutput("gap_tag_3", gpr_tag, 3);
    checkOutput("gap_raddr_b_3", gpr_raddr_b, 13);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("gap_ready_0", req_ready, 4'b0001);
    tick();
    checkOutput("gap_tag_0", gpr_tag, 0);

    // Idle: no grant, beat retires, pointer stays at 1
    applyStimulus(4'b0000, 1'b1);
    checkOutput("idle_ready", req_ready, 4'b0000);
    tick();
    checkOutput("idle_valid", gpr_valid, 0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("ptr_ready", req_ready, 4'b0100);
    tick();
    checkOutput("ptr_tag", gpr_tag, 2);
    checkOutput("ptr_wid", gpr_wid, 2);
    checkOutput("ptr_valid", gpr_valid, 1);

    // Reset with a beat held: outputs clear without a clock, pointer restarts at 0
    applyStimulus(4'b0000, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", gpr_valid, 0);
    checkOutput("midrst_tag", gpr_tag, 0);
    checkOutput("midrst_wid", gpr_wid, 0);
    checkOutput("midrst_raddr_a", gpr_raddr_a, 0);
    applyStimulus(4'hF, 1'b1);
    checkOutput("midrst_ready", req_ready, 4'b0000);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(4'b1010, 1'b1);
    checkOutput("postrst_ready", req_ready, 4'b0010);
    tick();
    checkOutput("postrst_tag", gpr_tag, 1);
    checkOutput("postrst_valid", gpr_valid, 1);
    checkOutput("postrst_last", gpr_last, 1);

`ifdef GPR_REQ_RS3_EN
    // Two-beat request from requester 2 (pointer now at 2)
    wid_t[2] = NW'(3);
    rs1_t[2] = NR'(5);
    rs2_t[2] = NR'(6);
    rs3_t[2] = NR'(7);
    use_t[2] = 1'b1;
    applyStimulus(4'b0100, 1'b1);
    checkOutput("rs3_grant_ready", req_ready, 4'b0100);
    tick();
    checkOutput("rs3_b0_a", gpr_raddr_a, 5);
    checkOutput("rs3_b0_b", gpr_raddr_b, 6);
    checkOutput("rs3_b0_phase", gpr_phase, 0);
    checkOutput("rs3_b0_last", gpr_last, 0);
    checkOutput("rs3_b0_wid", gpr_wid, 3);
    checkOutput("rs3_b0_tag", gpr_tag, 2);
    applyStimulus(4'hF, 1'b1);
    checkOutput("rs3_load_ready", req_ready, 4'b0000);
    tick();
    checkOutput("rs3_b1_a", gpr_raddr_a, 7);
    checkOutput("rs3_b1_b", gpr_raddr_b, 0);
    checkOutput("rs3_b1_phase", gpr_phase, 1);
    checkOutput("rs3_b1_last", gpr_last, 1);
    checkOutput("rs3_b1_wid", gpr_wid, 3);
    checkOutput("rs3_b1_tag", gpr_tag, 2);
    checkOutput("rs3_b1_valid", gpr_valid, 1);
    applyStimulus(4'hF, 1'b0);
    checkOutput("rs3_stall_ready", req_ready, 4'b0000);
    tick();
    checkOutput("rs3_stall_phase", gpr_phase, 1);
    checkOutput("rs3_stall_a", gpr_raddr_a, 7);

    // Reset while BEAT1 is held
    reset = 1'b0;
    #1;
    checkOutput("b1rst_valid", gpr_valid, 0);
    checkOutput("b1rst_phase", gpr_phase, 0);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(4'b1010, 1'b1);
    checkOutput("b1rst_ready", req_ready, 4'b0010);
    tick();
    checkOutput("b1rst_tag", gpr_tag, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
